trig_level_detect: RTL

TRIG_LEVEL_DETECT -- requirements
Module: trig_level_detect

---
 rtl/trig_pkg.sv | 23 ++
 rtl/trig_hyst_lane.sv | 27 ++
 rtl/trig_level_detect.sv | 135 +++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the level-trigger detector: default geometry,
// raw-state encoding and threshold saturation helpers.
package trig_pkg;

  localparam int unsigned TRIG_LANES = 4;
  localparam int unsigned TRIG_DW    = 8;

  localparam logic ST_BELOW = 1'b0;
  localparam logic ST_ABOVE = 1'b1;

  // Thresholds clamp at the sample range limits instead of wrapping.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned maxv);
    int unsigned s;
    s = a + b;
    return (s > maxv) ? maxv : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (b > a) ? 0 : a - b;
  endfunction

endpackage

// File: rtl/trig_hyst_lane.sv
// Single-lane hysteresis comparator; chained across lanes so each sample
// sees the state left by the previous (older) sample.
module trig_hyst_lane
  import trig_pkg::*;
#(
  parameter int unsigned DW = TRIG_DW
) (
  input  logic          state_in,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] upper,
  input  logic [DW-1:0] lower,
  output logic          state_out,
  output logic          crossed
);

  // Upper is tested first so that upper==lower lets a sample at level rise.
  always_comb begin
    state_out = state_in;
    if (state_in == ST_BELOW) begin
      if (sample >= upper) state_out = ST_ABOVE;
    end else begin
      if (sample <= lower) state_out = ST_BELOW;
    end
    crossed = (state_out != state_in);
  end

endmodule

// File: rtl/trig_level_detect.sv
// Multi-lane level trigger with hysteresis, sub-word glitch rejection and a
// consecutive-cycle noise filter feeding trig_ch and its edge events.
module trig_level_detect
  import trig_pkg::*;
#(
  parameter  int unsigned LANES = TRIG_LANES,
  parameter  int unsigned DW    = TRIG_DW,
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                rxclk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [LANES*DW-1:0] adc_data,
  input  logic                adc_valid,
  input  logic [DW-1:0]       level,
  input  logic [DW-1:0]       hyst,
  input  logic [7:0]          filt_len,
  input  logic                cfg_load,
  output logic                trig_ch,
  output logic                rise_evt,
  output logic                fall_evt,
  output logic [LW-1:0]       edge_lane
);

  localparam int unsigned SMAX = (1 << DW) - 1;

  logic [LANES*DW-1:0] data_q;
  logic                valid_q;
  logic [DW-1:0]       act_level;
  logic [DW-1:0]       act_hyst;
  logic [7:0]          act_filt;
  logic [DW-1:0]       upper;
  logic [DW-1:0]       lower;
  logic                raw_q;
  logic [LW-1:0]       pend_lane;
  logic [LANES:0]      st;
  logic [LANES-1:0]    crossed;
  logic [LW-1:0]       first_lane;
  logic                found;
  logic [7:0]          cnt;

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= adc_data;
      valid_q <= adc_valid;
    end
  end

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      act_level <= {1'b1, {(DW-1){1'b0}}};
      act_hyst  <= '0;
      act_filt  <= '0;
    end else if (cfg_load) begin
      act_level <= level;
      act_hyst  <= hyst;
      act_filt  <= filt_len;
    end
  end

  always_comb begin
    upper = DW'(sat_add(32'(act_level), 32'(act_hyst), SMAX));
    lower = DW'(sat_sub(32'(act_level), 32'(act_hyst)));
  end

  assign st[0] = raw_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    trig_hyst_lane #(.DW(DW)) u_lane (
      .state_in  (st[g]),
      .sample    (data_q[g*DW +: DW]),
      .upper     (upper),
      .lower     (lower),
      .state_out (st[g+1]),
      .crossed   (crossed[g])
    );
  end

  always_comb begin
    first_lane = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (crossed[i] && !found) begin
        first_lane = LW'(i);
        found      = 1'b1;
      end
    end
  end

  // A word that crosses and returns leaves st[LANES]==raw_q, so nothing latches.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q     <= ST_BELOW;
      pend_lane <= '0;
    end else if (!en) begin
      raw_q <= ST_BELOW;
    end else if (valid_q && (st[LANES] != raw_q)) begin
      raw_q     <= st[LANES];
      pend_lane <= first_lane;
    end
  end

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      trig_ch   <= 1'b0;
      rise_evt  <= 1'b0;
      fall_evt  <= 1'b0;
      edge_lane <= '0;
      cnt       <= '0;
    end else if (!en) begin
      trig_ch  <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      cnt      <= '0;
    end else begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      if (cfg_load || (raw_q == trig_ch)) begin
        cnt <= '0;
      end else if (cnt == act_filt) begin
        trig_ch   <= raw_q;
        rise_evt  <= raw_q;
        fall_evt  <= ~raw_q;
        edge_lane <= pend_lane;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
